load_store_format: RTL and testbench
====================================

LOAD_STORE_FORMAT -- requirements
Module: load_store_format

Interface
REQ-001 SHALL have parameter ZERO_UNUSED_LANES, default 1, meaning store-data lanes not enabled are 0 (1) or keep the shifted/replicated value (0).
REQ-002 SHALL have port cpu_clock_i  input  1  meaning sole clock; all state changes on its rising edge.
REQ-003 SHALL have port cpu_reset_i  input  1  meaning reset, synchronous, active-high.
REQ-004 SHALL have port valid_i  input  1  meaning the operands this cycle are valid.
REQ-005 SHALL have port addr_i  input  2  meaning byte offset, address bits [1:0].
REQ-006 SHALL have port mem_ctrl_i  input  3  meaning RISC-V funct3 (instr[14:12]).
REQ-007 SHALL have port ld_data_i  input  32  meaning raw aligned word read from memory.
REQ-008 SHALL have port st_data_i  input  32  meaning register value to store.
REQ-009 SHALL have port ld_data_o  output  32  meaning load result formatted for the register file.
REQ-010 SHALL have port st_data_o  output  32  meaning store data shifted to byte lanes.
REQ-011 SHALL have port st_be_o  output  4  meaning byte-lane write enables, bit k = bits [8k+7:8k].
REQ-012 SHALL have port valid_o  output  1  meaning outputs are valid.
REQ-013 SHALL have port misaligned_o  output  1  meaning misaligned access, present only with LSF_MISALIGN_EN.

Function
REQ-014 SHALL register all outputs, with a latency of 1 cycle from valid_i to valid_o; valid_o <= valid_i every cycle.
REQ-015 SHALL load the data registers only when valid_i=1 and otherwise hold them.
REQ-016 SHALL format loads as follows:
- 000 LB: byte at addr_i, sign-extended.
- 001 LH: halfword at addr_i[1], sign-extended.
- 010 LW: full word.
- 100 LBU: byte at addr_i, zero-extended.
- 101 LHU: halfword at addr_i[1], zero-extended.
- 011/110/111: full word unchanged.
REQ-017 SHALL, for halfword loads and stores, select lanes by addr_i[1] only; addr_i[0] is ignored.
REQ-018 SHALL use only mem_ctrl_i[1:0] for stores.
REQ-019 SHALL format stores as follows:
- 00 SB: st_data_i[7:0] placed in lane addr_i, st_be_o = 4'b0001 << addr_i.
- 01 SH: st_data_i[15:0] placed in lanes 2*addr_i[1]..+1, st_be_o = 4'b0011 << 2*addr_i[1].
- 10 SW: st_data_i unchanged, st_be_o = 4'b1111.
- 11: st_be_o = 4'b0000.
REQ-020 SHALL, when ZERO_UNUSED_LANES=1, make every non-enabled lane of st_data_o zero; when it is 0, replicate the byte or halfword across all lanes.
REQ-021 SHALL compute load and store formatting in parallel every cycle, regardless of access type.

Reset
REQ-022 SHALL, while cpu_reset_i=1 at a clock edge, set valid_o=0, ld_data_o=0, st_data_o=0, st_be_o=0 and misaligned_o=0.
REQ-023 SHALL give reset priority over valid_i, so that a reset asserted mid-stream discards the in-flight result.
REQ-024 SHALL allow outputs to update normally from the first edge after cpu_reset_i deasserts.

Configuration
REQ-025 SHALL use macro LSF_MISALIGN_EN to control the misalignment check.
REQ-026 SHALL, with LSF_MISALIGN_EN defined, register misaligned_o=1 when a halfword access has addr_i[0]=1 or a word access has addr_i!=0.
REQ-027 SHALL, with LSF_MISALIGN_EN defined, force st_be_o to 0 on a misaligned store; ld_data_o is still produced per REQ-016.
REQ-028 SHALL, without LSF_MISALIGN_EN, omit the misaligned_o port and never suppress st_be_o.

Verification
REQ-029 SHALL cover: ld_data_i=0x8899AABB, addr_i=2, funct3=000, valid_i=1 -> next cycle ld_data_o=0xFFFFFF99, valid_o=1.
REQ-030 SHALL cover: the same word with addr_i=2, funct3=101 -> ld_data_o=0x00008899; with funct3=001 and addr_i=0 -> ld_data_o=0xFFFFAABB.
REQ-031 SHALL cover: st_data_i=0x123456A5, addr_i=3, funct3=000 -> st_data_o=0xA5000000, st_be_o=4'b1000; with ZERO_UNUSED_LANES=0 -> st_data_o=0xA5A5A5A5.
REQ-032 SHALL cover: st_data_i=0x00001234, addr_i=2, funct3=001 -> st_data_o=0x12340000, st_be_o=4'b1100; funct3=010 -> st_be_o=4'b1111.
REQ-033 SHALL cover: valid_i=1 and cpu_reset_i=1 on the same edge -> next cycle valid_o=0, all outputs 0; after reset deasserts with valid_i=0 -> outputs hold 0.
REQ-034 SHALL cover, with LSF_MISALIGN_EN: SW with addr_i=2 -> misaligned_o=1, st_be_o=0000; LB with addr_i=3 -> misaligned_o=0.

Source files
------------

// File: rtl/load_store_format.sv
// +--------------------------------------------------------------------------+
// | Module   : load_store_format                                             |
// | Brief    : RISC-V load/store byte-lane formatter, one registered stage.  |
// |            Optional misalignment check enabled by macro LSF_MISALIGN_EN. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module load_store_format #(
  parameter int ZERO_UNUSED_LANES = 1
) (
  input  logic        cpu_clock_i,
  input  logic        cpu_reset_i,
  input  logic        valid_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  mem_ctrl_i,
  input  logic [31:0] ld_data_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_be_o,
`ifdef LSF_MISALIGN_EN
  output logic        misaligned_o,
`endif
  output logic        valid_o
);

  localparam logic [2:0] C_LB  = 3'b000;
  localparam logic [2:0] C_LH  = 3'b001;
  localparam logic [2:0] C_LBU = 3'b100;
  localparam logic [2:0] C_LHU = 3'b101;

  logic        valid_q;
  logic [31:0] ld_data_q, ld_data_d;
  logic [31:0] st_data_q, st_data_d;
  logic [3:0]  st_be_q,   st_be_d;
  logic        misaligned_d;

  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_st_rep;
  logic [31:0] w_lane_mask;
  logic [3:0]  w_st_be_raw;

  // Load path
  always_comb begin
    w_ld_byte = 8'h00;
    case (addr_i)
      2'd0:    w_ld_byte = ld_data_i[7:0];
      2'd1:    w_ld_byte = ld_data_i[15:8];
      2'd2:    w_ld_byte = ld_data_i[23:16];
      default: w_ld_byte = ld_data_i[31:24];
    endcase
    w_ld_half = addr_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];

    ld_data_d = ld_data_i;
    case (mem_ctrl_i)
      C_LB:    ld_data_d = {{24{w_ld_byte[7]}}, w_ld_byte};
      C_LH:    ld_data_d = {{16{w_ld_half[15]}}, w_ld_half};
      C_LBU:   ld_data_d = {24'h000000, w_ld_byte};
      C_LHU:   ld_data_d = {16'h0000, w_ld_half};
      default: ld_data_d = ld_data_i;
    endcase
  end

  // Store path: replicate the datum over all lanes, then optionally mask.
  always_comb begin
    w_st_rep    = st_data_i;
    w_st_be_raw = 4'b0000;
    case (mem_ctrl_i[1:0])
      2'b00: begin
        w_st_rep    = {4{st_data_i[7:0]}};
        w_st_be_raw = 4'b0001 << addr_i;
      end
      2'b01: begin
        w_st_rep    = {2{st_data_i[15:0]}};
        w_st_be_raw = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        w_st_rep    = st_data_i;
        w_st_be_raw = 4'b1111;
      end
      default: begin
        w_st_rep    = st_data_i;
        w_st_be_raw = 4'b0000;
      end
    endcase

    w_lane_mask = 32'h0;
    for (int k = 0; k < 4; k++) begin
      w_lane_mask[8*k +: 8] = {8{w_st_be_raw[k]}};
    end

    st_data_d = (ZERO_UNUSED_LANES != 0) ? (w_st_rep & w_lane_mask) : w_st_rep;
  end

  // Halfword and word classes come from funct3[1:0] for both loads and stores.
  always_comb begin
    misaligned_d = 1'b0;
`ifdef LSF_MISALIGN_EN
    misaligned_d = ((mem_ctrl_i[1:0] == 2'b01) && addr_i[0]) ||
                   ((mem_ctrl_i[1:0] == 2'b10) && (addr_i != 2'b00));
`endif
    st_be_d = misaligned_d ? 4'b0000 : w_st_be_raw;
  end

`ifdef LSF_MISALIGN_EN
  logic misaligned_q;
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      misaligned_q <= 1'b0;
    end else if (valid_i) begin
      misaligned_q <= misaligned_d;
    end
  end
  assign misaligned_o = misaligned_q;
`endif

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      valid_q   <= 1'b0;
      ld_data_q <= 32'h0;
      st_data_q <= 32'h0;
      st_be_q   <= 4'b0000;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        ld_data_q <= ld_data_d;
        st_data_q <= st_data_d;
        st_be_q   <= st_be_d;
      end
    end
  end

  assign valid_o   = valid_q;
  assign ld_data_o = ld_data_q;
  assign st_data_o = st_data_q;
  assign st_be_o   = st_be_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_format.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_load_store_format                                          |
// | Brief    : Directed vectors for load_store_format, both lane-fill modes. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_load_store_format;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [1:0]  addr_i;
  logic [2:0]  mem_ctrl_i;
  logic [31:0] ld_data_i;
  logic [31:0] st_data_i;

  logic [31:0] ld_z, st_z, ld_r, st_r;
  logic [3:0]  be_z, be_r;
  logic        v_z, v_r;
`ifdef LSF_MISALIGN_EN
  logic        mis_z, mis_r;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_format #(.ZERO_UNUSED_LANES(1)) u_dut_zero (
    .cpu_clock_i (clk),
    .cpu_reset_i (rst),
    .valid_i     (valid_i),
    .addr_i      (addr_i),
    .mem_ctrl_i  (mem_ctrl_i),
    .ld_data_i   (ld_data_i),
    .st_data_i   (st_data_i),
    .ld_data_o   (ld_z),
    .st_data_o   (st_z),
    .st_be_o     (be_z),
`ifdef LSF_MISALIGN_EN
    .misaligned_o(mis_z),
`endif
    .valid_o     (v_z)
  );

  load_store_format #(.ZERO_UNUSED_LANES(0)) u_dut_rep (
    .cpu_clock_i (clk),
    .cpu_reset_i (rst),
    .valid_i     (valid_i),
    .addr_i      (addr_i),
    .mem_ctrl_i  (mem_ctrl_i),
    .ld_data_i   (ld_data_i),
    .st_data_i   (st_data_i),
    .ld_data_o   (ld_r),
    .st_data_o   (st_r),
    .st_be_o     (be_r),
`ifdef LSF_MISALIGN_EN
    .misaligned_o(mis_r),
`endif
    .valid_o     (v_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample #1 after the capturing edge.
  task automatic step(input logic r, input logic v, input logic [1:0] a,
                      input logic [2:0] f, input logic [31:0] ld, input logic [31:0] st);
    rst        = r;
    valid_i    = v;
    addr_i     = a;
    mem_ctrl_i = f;
    ld_data_i  = ld;
    st_data_i  = st;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'h0, v_z}, 32'h0);
    check({tag, "_ld"},    ld_z, 32'h0);
    check({tag, "_st"},    st_z, 32'h0);
    check({tag, "_be"},    {28'h0, be_z}, 32'h0);
`ifdef LSF_MISALIGN_EN
    check({tag, "_mis"},   {31'h0, mis_z}, 32'h0);
`endif
  endtask

  initial begin
    step(1'b1, 1'b0, 2'd0, 3'b000, 32'h0, 32'h0);
    step(1'b1, 1'b0, 2'd0, 3'b000, 32'h0, 32'h0);
    check_all_zero("reset");

    // Loads
    step(1'b0, 1'b1, 2'd2, 3'b000, 32'h8899AABB, 32'h0);
    check("lb_a2", ld_z, 32'hFFFFFF99);
    check("lb_a2_valid", {31'h0, v_z}, 32'h1);
    step(1'b0, 1'b1, 2'd2, 3'b101, 32'h8899AABB, 32'h0);
    check("lhu_a2", ld_z, 32'h00008899);
    step(1'b0, 1'b1, 2'd0, 3'b001, 32'h8899AABB, 32'h0);
    check("lh_a0", ld_z, 32'hFFFFAABB);
    step(1'b0, 1'b1, 2'd3, 3'b100, 32'h8899AABB, 32'h0);
    check("lbu_a3", ld_z, 32'h00000088);
    step(1'b0, 1'b1, 2'd1, 3'b000, 32'h8899AA7B, 32'h0);
    check("lb_a1", ld_z, 32'hFFFFFFAA);
    step(1'b0, 1'b1, 2'd0, 3'b000, 32'h8899AA7B, 32'h0);
    check("lb_a0_pos", ld_z, 32'h0000007B);
    step(1'b0, 1'b1, 2'd3, 3'b001, 32'h8899AABB, 32'h0);
    check("lh_a3_ignores_a0", ld_z, 32'hFFFF8899);
`ifdef LSF_MISALIGN_EN
    check("lh_a3_mis", {31'h0, mis_z}, 32'h1);
`endif
    step(1'b0, 1'b1, 2'd0, 3'b010, 32'h8899AABB, 32'h0);
    check("lw", ld_z, 32'h8899AABB);
    step(1'b0, 1'b1, 2'd0, 3'b111, 32'h01234567, 32'h0);
    check("f111_word", ld_z, 32'h01234567);

    // Stores
    step(1'b0, 1'b1, 2'd3, 3'b000, 32'h0, 32'h123456A5);
    check("sb_a3", st_z, 32'hA5000000);
    check("sb_a3_be", {28'h0, be_z}, 32'h8);
    check("sb_a3_rep", st_r, 32'hA5A5A5A5);
    check("sb_a3_rep_be", {28'h0, be_r}, 32'h8);
`ifdef LSF_MISALIGN_EN
    check("sb_a3_mis", {31'h0, mis_z}, 32'h0);
`endif
    step(1'b0, 1'b1, 2'd1, 3'b000, 32'h0, 32'h123456A5);
    check("sb_a1", st_z, 32'h0000A500);
    check("sb_a1_be", {28'h0, be_z}, 32'h2);
    step(1'b0, 1'b1, 2'd2, 3'b001, 32'h0, 32'h00001234);
    check("sh_a2", st_z, 32'h12340000);
    check("sh_a2_be", {28'h0, be_z}, 32'hC);
    check("sh_a2_rep", st_r, 32'h12341234);
    step(1'b0, 1'b1, 2'd0, 3'b101, 32'h0, 32'hCAFE5678);
    check("sh_f101_a0", st_z, 32'h00005678);
    check("sh_f101_a0_be", {28'h0, be_z}, 32'h3);
    step(1'b0, 1'b1, 2'd0, 3'b010, 32'h0, 32'h00001234);
    check("sw_a0", st_z, 32'h00001234);
    check("sw_a0_be", {28'h0, be_z}, 32'hF);
    step(1'b0, 1'b1, 2'd1, 3'b011, 32'h0, 32'hDEADBEEF);
    check("f011_be", {28'h0, be_z}, 32'h0);
    check("f011_st_zero", st_z, 32'h0);
    check("f011_st_rep", st_r, 32'hDEADBEEF);

    // Hold when valid_i is low
    step(1'b0, 1'b0, 2'd0, 3'b000, 32'h11111111, 32'h22222222);
    check("hold_valid", {31'h0, v_z}, 32'h0);
    check("hold_st", st_r, 32'hDEADBEEF);
    check("hold_ld", ld_z, 32'hDEADBEEF & 32'h0 | 32'h8899AABB & 32'h0 | ld_z & 32'h0 | 32'h0);
    check("hold_ld_val", ld_r, 32'h00000000);

    // Misaligned word store
    step(1'b0, 1'b1, 2'd2, 3'b010, 32'h0, 32'hABCD0123);
`ifdef LSF_MISALIGN_EN
    check("sw_a2_mis", {31'h0, mis_z}, 32'h1);
    check("sw_a2_be", {28'h0, be_z}, 32'h0);
`else
    check("sw_a2_be", {28'h0, be_z}, 32'hF);
`endif
    check("sw_a2_st", st_z, 32'hABCD0123);

    // Reset beats a simultaneous valid, then outputs stay 0 with valid_i low
    step(1'b1, 1'b1, 2'd0, 3'b010, 32'h8899AABB, 32'h12345678);
    check_all_zero("rst_with_valid");
    step(1'b0, 1'b0, 2'd0, 3'b010, 32'h8899AABB, 32'h12345678);
    check_all_zero("post_rst_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
